// File: rtl/fir_frame_sched.sv
// fir_frame_sched
// Pixel-clock controller between the CPU register side and the sobel datapath.
// FIR coefficients are staged in a shadow bank and streamed into the datapath
// only after a vertical-sync edge, so one frame never sees a mixed coefficient
// set. Histogram bins are drained from the datapath through a one-entry buffer.
//
// Handshake on the histogram read side: a bin moves from the buffer to the
// consumer on every clk edge where hist_rd_valid=1 and hist_rd_ready=1. Once
// hist_rd_valid is high, hist_rd_data and hist_rd_idx are held until that
// transfer happens. A refill may happen on the same edge as the transfer, so a
// steady stream runs without bubbles.
module fir_frame_sched #(
    parameter int NUM_COEF  = 9,
    parameter int COEF_W    = 16,
    parameter int HIST_BINS = 256,
    parameter int BIN_W     = 16,
    parameter bit VS_POL    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vs_i,
    input  logic                         dv_i,
    input  logic                         cfg_wr,
    input  logic [$clog2(NUM_COEF)-1:0]  cfg_addr,
    input  logic [COEF_W-1:0]            cfg_data,
    input  logic                         cfg_commit,
    output logic                         cfg_busy,
    output logic                         load_done,
    output logic                         load_err,
    output logic                         fir_coef_write,
    output logic [COEF_W-1:0]            fir_coef_data,
    input  logic                         hist_bin_ready,
    input  logic [BIN_W-1:0]             hist_bin_data,
    output logic                         hist_bin_saved,
    output logic                         hist_rd_valid,
    input  logic                         hist_rd_ready,
    output logic [BIN_W-1:0]             hist_rd_data,
    output logic [$clog2(HIST_BINS)-1:0] hist_rd_idx,
    output logic                         hist_done,
    output logic [15:0]                  frame_cnt,
    output logic [1:0]                   dbg_state
);

    localparam int AW = $clog2(NUM_COEF);
    localparam int IW = $clog2(NUM_COEF + 1);
    localparam int HW = $clog2(HIST_BINS);

    // idx counts one past the coefficient currently on the bus
    localparam logic [IW-1:0] IDX_END  = IW'(NUM_COEF);
    localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(NUM_COEF);
    localparam logic [HW-1:0] BIN_LAST = HW'(HIST_BINS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [COEF_W-1:0]  shadow [NUM_COEF];
    logic               vs_d;
    logic               vs_act;
    logic               vs_edge;
    logic [HW-1:0]      bin_cnt;
    logic               cap;
    logic               pop;

    assign vs_act    = (vs_i == VS_POL);
    assign vs_edge   = vs_act & ~vs_d;
    assign cap       = hist_bin_ready & (~hist_rd_valid | hist_rd_ready);
    assign pop       = hist_rd_valid & hist_rd_ready;
    assign dbg_state = state;

    // Sync-edge detector and frame counter, running in every FSM state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_d      <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            vs_d <= vs_act;
            if (vs_edge)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Shadow bank: frozen while a commit is pending or a load is running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_COEF; i++)
                shadow[i] <= '0;
        end else if (cfg_wr && !cfg_busy && ({1'b0, cfg_addr} < ADDR_LIM)) begin
            shadow[cfg_addr] <= cfg_data;
        end
    end

    // Load sequencer: commit arms it, the next sync edge streams the bank out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            idx            <= '0;
            cfg_busy       <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            fir_coef_write <= 1'b0;
            fir_coef_data  <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_commit) begin
                        state    <= WAIT_VS;
                        cfg_busy <= 1'b1;
                        load_err <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    if (vs_edge) begin
                        state          <= LOAD;
                        fir_coef_write <= 1'b1;
                        fir_coef_data  <= shadow[0];
                        idx            <= IW'(1);
                    end
                end
                LOAD: begin
                    if (dv_i)
                        load_err <= 1'b1;
                    if (idx < IDX_END) begin
                        fir_coef_data <= shadow[idx[AW-1:0]];
                        idx           <= idx + 1'b1;
                    end else begin
                        fir_coef_write <= 1'b0;
                        load_done      <= 1'b1;
                        cfg_busy       <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    cfg_busy       <= 1'b0;
                    fir_coef_write <= 1'b0;
                end
            endcase
        end
    end

    // One-entry histogram buffer; capture and hand-off can share an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_rd_valid  <= 1'b0;
            hist_rd_data   <= '0;
            hist_rd_idx    <= '0;
            hist_bin_saved <= 1'b0;
            hist_done      <= 1'b0;
            bin_cnt        <= '0;
        end else begin
            hist_bin_saved <= cap;
            hist_done      <= cap && (bin_cnt == BIN_LAST);
            if (cap) begin
                hist_rd_data  <= hist_bin_data;
                hist_rd_idx   <= bin_cnt;
                hist_rd_valid <= 1'b1;
                bin_cnt       <= (bin_cnt == BIN_LAST) ? '0 : bin_cnt + 1'b1;
            end else if (pop) begin
                hist_rd_valid <= 1'b0;
            end
        end
    end

endmodule
